// File: rtl/cpu_state_controller_if.sv
// Fetch/data-memory handshake bundle for cpu_state_controller.
// master = controller side, slave = memory/environment side.
interface cpu_state_controller_if #(
    parameter int INST_W = 32
);
    logic              i_start;
    logic              i_imem_valid;
    logic [INST_W-1:0] i_inst;
    logic              i_dmem_valid;
    logic              o_imem_req;
    logic              o_dmem_req;
    logic              o_dmem_we;

    modport master (
        input  i_start,
        input  i_imem_valid,
        input  i_inst,
        input  i_dmem_valid,
        output o_imem_req,
        output o_dmem_req,
        output o_dmem_we
    );

    modport slave (
        output i_start,
        output i_imem_valid,
        output i_inst,
        output i_dmem_valid,
        input  o_imem_req,
        input  o_dmem_req,
        input  o_dmem_we
    );
endinterface

// File: rtl/cpu_state_controller.sv
// Multi-cycle fetch/decode/execute control FSM for the RV64I-subset CPU.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module cpu_state_controller #(
    parameter int INST_W       = 32,
    parameter int STATE_W      = 5,
    parameter int IMEM_TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    cpu_state_controller_if.master bus,
    output logic [STATE_W-1:0] o_state,
    output logic               o_RegWrite,
    output logic [4:0]         o_read_register1,
    output logic [4:0]         o_read_register2,
    output logic [4:0]         o_write_register,
    output logic               o_pc_en,
    output logic               o_halt,
    output logic               o_error
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]        o_cycle_cnt,
    output logic [31:0]        o_inst_cnt
`endif
);

    typedef enum logic [4:0] {
        S_IDLE     = 5'd0,
        S_IF_REQ   = 5'd1,
        S_IF_WAIT  = 5'd2,
        S_ID       = 5'd3,
        S_RF_READ  = 5'd4,
        S_EX       = 5'd5,
        S_MEM_REQ  = 5'd6,
        S_MEM_WAIT = 5'd7,
        S_WB       = 5'd10,
        S_PC_UPD   = 5'd11,
        S_HALT     = 5'd12
    } state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    localparam bit TO_EN = (IMEM_TIMEOUT > 0);
    localparam int CNT_W = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((IMEM_TIMEOUT > 0) ? IMEM_TIMEOUT - 1 : 0);

    state_e            state_q;
    logic [INST_W-1:0] inst_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              error_q;

    logic [6:0] opcode;
    logic       is_store;
    logic       is_mem;
    logic       is_alu;
    logic       to_hit;

    assign opcode   = inst_q[6:0];
    assign is_store = (opcode == OP_STORE);
    assign is_mem   = (opcode == OP_LOAD) || is_store;
    assign is_alu   = (opcode == OP_RTYPE) || (opcode == OP_ITYPE);
    // Counter holds cycles already spent waiting; this is the last allowed one.
    assign to_hit   = TO_EN && (cnt_q == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            inst_q  <= '0;
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.i_start) state_q <= S_IF_REQ;
                end
                S_IF_REQ: begin
                    cnt_q   <= '0;
                    state_q <= S_IF_WAIT;
                end
                S_IF_WAIT: begin
                    if (bus.i_imem_valid) begin
                        inst_q  <= bus.i_inst;
                        state_q <= S_ID;
                    end else if (to_hit) begin
                        error_q <= 1'b1;
                        state_q <= S_HALT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_ID: begin
                    state_q <= (&inst_q) ? S_HALT : S_RF_READ;
                end
                S_RF_READ: begin
                    state_q <= S_EX;
                end
                S_EX: begin
                    // Branches and unknown opcodes only advance the PC.
                    unique case (1'b1)
                        is_mem:  state_q <= S_MEM_REQ;
                        is_alu:  state_q <= S_WB;
                        default: state_q <= S_PC_UPD;
                    endcase
                end
                S_MEM_REQ: begin
                    cnt_q   <= '0;
                    state_q <= S_MEM_WAIT;
                end
                S_MEM_WAIT: begin
                    if (bus.i_dmem_valid) begin
                        state_q <= is_store ? S_PC_UPD : S_WB;
                    end else if (to_hit) begin
                        error_q <= 1'b1;
                        state_q <= S_HALT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WB: begin
                    state_q <= S_PC_UPD;
                end
                S_PC_UPD: begin
                    state_q <= S_IF_REQ;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_state          = STATE_W'(state_q);
    assign o_read_register1 = inst_q[19:15];
    assign o_read_register2 = inst_q[24:20];
    assign o_write_register = inst_q[11:7];

    // Strobes decode only the registered state, so they track o_state exactly.
    assign bus.o_imem_req = (state_q == S_IF_REQ);
    assign bus.o_dmem_req = (state_q == S_MEM_REQ);
    assign bus.o_dmem_we  = (state_q == S_MEM_REQ) && is_store;
    assign o_RegWrite     = (state_q == S_WB) && (inst_q[11:7] != 5'd0);
    assign o_pc_en        = (state_q == S_PC_UPD);
    assign o_halt         = (state_q == S_HALT);
    assign o_error        = error_q;

`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] inst_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
        end else begin
            if (state_q != S_IDLE && state_q != S_HALT) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            end
            if (state_q == S_PC_UPD) begin
                inst_cnt_q <= inst_cnt_q + 32'd1;
            end
        end
    end

    assign o_cycle_cnt = cycle_cnt_q;
    assign o_inst_cnt  = inst_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_state_controller.sv
// Directed self-checking bench for cpu_state_controller.
// Runs a small instruction program plus reset, halt and timeout scenarios.
module tb_cpu_state_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] o_state;
    logic       o_RegWrite;
    logic [4:0] o_read_register1;
    logic [4:0] o_read_register2;
    logic [4:0] o_write_register;
    logic       o_pc_en;
    logic       o_halt;
    logic       o_error;
`ifdef PERF_CNT_EN
    logic [31:0] o_cycle_cnt;
    logic [31:0] o_inst_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] st_tr [64];
    logic       rw_tr [64];
    logic       pc_tr [64];
    logic       dr_tr [64];
    logic       dw_tr [64];
    int         tr_n;

    cpu_state_controller_if bus ();

    cpu_state_controller dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .bus              (bus),
        .o_state          (o_state),
        .o_RegWrite       (o_RegWrite),
        .o_read_register1 (o_read_register1),
        .o_read_register2 (o_read_register2),
        .o_write_register (o_write_register),
        .o_pc_en          (o_pc_en),
        .o_halt           (o_halt),
        .o_error          (o_error)
`ifdef PERF_CNT_EN
        ,
        .o_cycle_cnt      (o_cycle_cnt),
        .o_inst_cnt       (o_inst_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.i_start = 1'b0;
        bus.i_imem_valid = 1'b0;
        bus.i_dmem_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Memory responder: records one instruction's trace from IF_REQ onward.
    task automatic run_inst(input logic [31:0] inst, input int ilat,
                            input int dlat);
        int iw;
        int dw;
        iw = 0;
        dw = 0;
        tr_n = 0;
        bus.i_inst = inst;
        forever begin
            st_tr[tr_n] = o_state;
            rw_tr[tr_n] = o_RegWrite;
            pc_tr[tr_n] = o_pc_en;
            dr_tr[tr_n] = bus.o_dmem_req;
            dw_tr[tr_n] = bus.o_dmem_we;
            tr_n++;
            bus.i_imem_valid = 1'b0;
            bus.i_dmem_valid = 1'b0;
            if (o_state == 5'd2) begin
                if (iw >= ilat) bus.i_imem_valid = 1'b1;
                else iw++;
            end
            if (o_state == 5'd7) begin
                if (dw >= dlat) bus.i_dmem_valid = 1'b1;
                else dw++;
            end
            step();
            if (o_state == 5'd1 || o_state == 5'd12 || tr_n >= 40) break;
        end
        bus.i_imem_valid = 1'b0;
        bus.i_dmem_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_start = 1'b0;
        bus.i_imem_valid = 1'b0;
        bus.i_dmem_valid = 1'b0;
        bus.i_inst = 32'h0;
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if ({o_state, o_RegWrite, o_read_register1, o_read_register2,
             o_write_register, bus.o_imem_req, bus.o_dmem_req,
             bus.o_dmem_we, o_pc_en, o_halt, o_error} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: state=%0d rw=%b halt=%b err=%b expected all 0",
                     o_state, o_RegWrite, o_halt, o_error);
        end
        rst_n = 1'b1;
        step();
        step();
        n_checks++;
        if (o_state !== 5'd0) begin
            n_fail++;
            $display("FAIL idle_hold: state=%0d expected 0", o_state);
        end
    endtask

    task automatic test_reset_mid_mem();
        apply_reset();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        bus.i_inst = 32'h0080B283;
        for (int i = 0; i < 20; i++) begin
            if (o_state == 5'd7) break;
            bus.i_imem_valid = (o_state == 5'd2);
            step();
        end
        bus.i_imem_valid = 1'b0;
        n_checks++;
        if (o_state !== 5'd7) begin
            n_fail++;
            $display("FAIL reach_mem_wait: state=%0d expected 7", o_state);
        end
        rst_n = 1'b0;
        bus.i_dmem_valid = 1'b1;
        #1;
        n_checks++;
        if ({o_state, o_RegWrite, o_read_register1, o_read_register2,
             o_write_register, bus.o_imem_req, bus.o_dmem_req,
             bus.o_dmem_we, o_pc_en, o_halt, o_error} !== 27'd0) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d rd=%0d rw=%b expected all 0",
                     o_state, o_write_register, o_RegWrite);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (o_state !== 5'd0 || o_RegWrite !== 1'b0 ||
                bus.o_dmem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_valid[%0d]: state=%0d rw=%b expected state 0 rw 0",
                         i, o_state, o_RegWrite);
            end
        end
        bus.i_dmem_valid = 1'b0;
    endtask

    task automatic test_add();
        logic [4:0] e [7];
        e = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd10, 5'd11};
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        n_checks++;
        if (o_state !== 5'd1 || bus.o_imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL add_ifreq: state=%0d req=%b expected 1/1",
                     o_state, bus.o_imem_req);
        end
        run_inst(32'h002081B3, 0, 0);
        n_checks++;
        if (tr_n !== 7) begin
            n_fail++;
            $display("FAIL add_len: got %0d expected 7", tr_n);
        end
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (st_tr[i] !== e[i] || rw_tr[i] !== (i == 5) ||
                pc_tr[i] !== (i == 6)) begin
                n_fail++;
                $display("FAIL add_cyc[%0d]: state=%0d rw=%b pc=%b expected %0d %b %b",
                         i, st_tr[i], rw_tr[i], pc_tr[i], e[i], i == 5, i == 6);
            end
        end
        n_checks++;
        if (o_read_register1 !== 5'd1 || o_read_register2 !== 5'd2 ||
            o_write_register !== 5'd3) begin
            n_fail++;
            $display("FAIL add_fields: rs1=%0d rs2=%0d rd=%0d expected 1 2 3",
                     o_read_register1, o_read_register2, o_write_register);
        end
`ifdef PERF_CNT_EN
        n_checks++;
        if (o_cycle_cnt !== 32'd7 || o_inst_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL add_perf: cyc=%0d inst=%0d expected 7 1",
                     o_cycle_cnt, o_inst_cnt);
        end
`endif
    endtask

    task automatic test_load();
        logic [4:0] e [12];
        e = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd7, 5'd7, 5'd7,
              5'd10, 5'd11};
        run_inst(32'h0080B283, 0, 3);
        n_checks++;
        if (tr_n !== 12) begin
            n_fail++;
            $display("FAIL ld_len: got %0d expected 12", tr_n);
        end
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (st_tr[i] !== e[i] || dr_tr[i] !== (i == 5) ||
                dw_tr[i] !== 1'b0 || rw_tr[i] !== (i == 10)) begin
                n_fail++;
                $display("FAIL ld_cyc[%0d]: state=%0d dreq=%b we=%b rw=%b expected %0d %b 0 %b",
                         i, st_tr[i], dr_tr[i], dw_tr[i], rw_tr[i], e[i],
                         i == 5, i == 10);
            end
        end
        n_checks++;
        if (o_write_register !== 5'd5 || o_read_register1 !== 5'd1) begin
            n_fail++;
            $display("FAIL ld_fields: rd=%0d rs1=%0d expected 5 1",
                     o_write_register, o_read_register1);
        end
    endtask

    task automatic test_store();
        logic [4:0] e [8];
        e = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd11};
        run_inst(32'h0020B823, 0, 0);
        n_checks++;
        if (tr_n !== 8) begin
            n_fail++;
            $display("FAIL sd_len: got %0d expected 8", tr_n);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (st_tr[i] !== e[i] || dr_tr[i] !== (i == 5) ||
                dw_tr[i] !== (i == 5) || rw_tr[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL sd_cyc[%0d]: state=%0d dreq=%b we=%b rw=%b expected %0d %b %b 0",
                         i, st_tr[i], dr_tr[i], dw_tr[i], rw_tr[i], e[i],
                         i == 5, i == 5);
            end
        end
        n_checks++;
        if (o_read_register2 !== 5'd2 || o_read_register1 !== 5'd1) begin
            n_fail++;
            $display("FAIL sd_fields: rs1=%0d rs2=%0d expected 1 2",
                     o_read_register1, o_read_register2);
        end
    endtask

    task automatic test_x0_write();
        logic [4:0] e [9];
        e = '{5'd1, 5'd2, 5'd2, 5'd2, 5'd3, 5'd4, 5'd5, 5'd10, 5'd11};
        run_inst(32'h00100013, 2, 0);
        n_checks++;
        if (tr_n !== 9) begin
            n_fail++;
            $display("FAIL x0_len: got %0d expected 9", tr_n);
        end
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (st_tr[i] !== e[i] || rw_tr[i] !== 1'b0 ||
                pc_tr[i] !== (i == 8)) begin
                n_fail++;
                $display("FAIL x0_cyc[%0d]: state=%0d rw=%b pc=%b expected %0d 0 %b",
                         i, st_tr[i], rw_tr[i], pc_tr[i], e[i], i == 8);
            end
        end
        n_checks++;
        if (o_write_register !== 5'd0) begin
            n_fail++;
            $display("FAIL x0_rd: got %0d expected 0", o_write_register);
        end
    endtask

    task automatic test_branch();
        logic [4:0] e [6];
        e = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd11};
        run_inst(32'h00000063, 0, 0);
        n_checks++;
        if (tr_n !== 6) begin
            n_fail++;
            $display("FAIL br_len: got %0d expected 6", tr_n);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (st_tr[i] !== e[i] || rw_tr[i] !== 1'b0 ||
                dr_tr[i] !== 1'b0 || pc_tr[i] !== (i == 5)) begin
                n_fail++;
                $display("FAIL br_cyc[%0d]: state=%0d rw=%b dreq=%b pc=%b expected %0d 0 0 %b",
                         i, st_tr[i], rw_tr[i], dr_tr[i], pc_tr[i], e[i], i == 5);
            end
        end
    endtask

    task automatic test_halt();
        run_inst(32'hFFFFFFFF, 0, 0);
        n_checks++;
        if (tr_n !== 3 || o_state !== 5'd12 || o_halt !== 1'b1 ||
            o_error !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_entry: len=%0d state=%0d halt=%b err=%b expected 3 12 1 0",
                     tr_n, o_state, o_halt, o_error);
        end
        bus.i_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (o_state !== 5'd12 || o_halt !== 1'b1 || o_pc_en !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_sticky[%0d]: state=%0d halt=%b expected 12 1",
                         i, o_state, o_halt);
            end
        end
        bus.i_start = 1'b0;
    endtask

    task automatic test_timeout();
        int k;
        logic early_err;
        apply_reset();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        step();
        k = 0;
        early_err = 1'b0;
        while (o_state == 5'd2 && k < 300) begin
            if (o_error !== 1'b0) early_err = 1'b1;
            k++;
            step();
        end
        n_checks++;
        if (k !== 255 || early_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_wait_cycles: got %0d early_err=%b expected 255 0",
                     k, early_err);
        end
        n_checks++;
        if (o_state !== 5'd12 || o_error !== 1'b1 || o_halt !== 1'b1) begin
            n_fail++;
            $display("FAIL to_halt: state=%0d err=%b halt=%b expected 12 1 1",
                     o_state, o_error, o_halt);
        end
    endtask

    task automatic test_timeout_valid_wins();
        int k;
        apply_reset();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        step();
        k = 0;
        while (o_state == 5'd2 && k < 254) begin
            k++;
            step();
        end
        n_checks++;
        if (k !== 254 || o_state !== 5'd2) begin
            n_fail++;
            $display("FAIL tv_wait: k=%0d state=%0d expected 254 2", k, o_state);
        end
        bus.i_inst = 32'h002081B3;
        bus.i_imem_valid = 1'b1;
        step();
        bus.i_imem_valid = 1'b0;
        n_checks++;
        if (o_state !== 5'd3 || o_error !== 1'b0) begin
            n_fail++;
            $display("FAIL tv_valid_wins: state=%0d err=%b expected 3 0",
                     o_state, o_error);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_mem();
        test_add();
        test_load();
        test_store();
        test_x0_write();
        test_branch();
        test_halt();
        test_timeout();
        test_timeout_valid_wins();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_state_controller.md
Name: cpu_state_controller

Overview:
- Multi-cycle control FSM for the 64-bit RV64I-subset CPU.
- Fetches each 32-bit instruction over a request/valid handshake and decodes the opcode.
- Drives the register-file control: 5-bit state bus, RegWrite, rs1/rs2/rd fields.
- Drives the data-memory request and the PC enable.
- Writeback is state 10, which is the only state in which the register file commits a write.

Parameters:
- INST_W, 32, instruction width.
- STATE_W, 5, width of the state bus.
- IMEM_TIMEOUT, 255, max cycles in IF_WAIT or MEM_WAIT before error halt; 0 disables the timeout.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  start pulse, sampled only in IDLE
- i_imem_valid  input  1  instruction data valid, sampled only in IF_WAIT
- i_inst  input  INST_W  instruction, latched when i_imem_valid in IF_WAIT
- i_dmem_valid  input  1  data-memory completion, sampled only in MEM_WAIT
- o_state  output  STATE_W  current state encoding, to register file i_state
- o_RegWrite  output  1  write enable to register file
- o_read_register1  output  5  latched inst[19:15]
- o_read_register2  output  5  latched inst[24:20]
- o_write_register  output  5  latched inst[11:7]
- o_imem_req  output  1  one-cycle fetch request pulse
- o_dmem_req  output  1  one-cycle data request pulse
- o_dmem_we  output  1  store qualifier, high only with o_dmem_req
- o_pc_en  output  1  PC advance strobe
- o_halt  output  1  sticky halt
- o_error  output  1  sticky timeout error

Behaviour:
- Reset: clock is i_clk; reset i_rst_n is asynchronous, active-low.
  - During reset, state = IDLE and every output is 0.
  - Latched instruction = 0; timeout counter = 0.
  - Reset mid-operation aborts immediately; any pending valid is ignored afterwards.
- State encoding: IDLE=0, IF_REQ=1, IF_WAIT=2, ID=3, RF_READ=4, EX=5, MEM_REQ=6, MEM_WAIT=7, WB=10, PC_UPD=11, HALT=12.
  - Unused codes go to IDLE on the next cycle.
- o_state is the registered current state.
- IDLE -> IF_REQ when i_start=1.
- IF_REQ: o_imem_req=1 for this cycle only, then -> IF_WAIT.
- IF_WAIT: hold until i_imem_valid=1, then latch i_inst -> ID.
  - Memory responds at least 1 cycle after the request; valid in IF_REQ is ignored.
- ID:
  - inst==32'hFFFFFFFF -> HALT.
  - Otherwise -> RF_READ. This extra cycle covers the register file's 1-cycle registered read.
- RF_READ -> EX.
- EX, routed by opcode inst[6:0]:
  - Load 0000011 and store 0100011 -> MEM_REQ.
  - R-type 0110011 and I-type 0010011 -> WB.
  - Branch 1100011 and any unknown opcode (treated as NOP) -> PC_UPD.
- MEM_REQ: o_dmem_req=1 for one cycle; o_dmem_we=1 only for store. Then -> MEM_WAIT.
- MEM_WAIT on i_dmem_valid: load -> WB; store -> PC_UPD.
- WB: o_RegWrite=1 iff rd!=0. Writes to x0 are suppressed. Then -> PC_UPD.
- PC_UPD: o_pc_en=1 for one cycle, then -> IF_REQ.
- HALT: o_halt=1, sticky until reset. i_start is ignored.
- All one-cycle strobes are combinational decodes of the registered state. They are glitch-free relative to o_state.
- i_start outside IDLE is ignored. Valids outside their wait states are ignored.
- Timeout (when IMEM_TIMEOUT>0):
  - The counter clears on entry to IF_WAIT or MEM_WAIT and counts each cycle spent there.
  - Reaching IMEM_TIMEOUT with no valid sets o_error=1 and -> HALT.
  - If valid arrives in the same cycle the limit is reached, valid wins.
- Zero-wait latency per instruction: R/I = 7 cycles, load = 9, store = 8, branch = 6.

Optional Feature:
- Macro: PERF_CNT_EN.
- When defined, add two outputs:
  - o_cycle_cnt[31:0]: increments every cycle the state is not IDLE or HALT.
  - o_inst_cnt[31:0]: increments in PC_UPD.
  - Both reset to 0 and wrap at 2^32.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-MEM_WAIT, then release and assert i_dmem_valid -> state 0, all outputs 0, no o_RegWrite.
- Start, zero-wait fetch of 0x002081B3 (add x3,x1,x2):
  - States 1,2,3,4,5,10,11.
  - rs1=1, rs2=2, rd=3.
  - o_RegWrite=1 only in state 10; o_pc_en in state 11.
  - With PERF_CNT_EN: cycle_cnt=7, inst_cnt=1.
- Load 0x0080B283 (ld x5,8(x1)) with i_dmem_valid 3 cycles late:
  - o_dmem_req=1, o_dmem_we=0 for one cycle.
  - Waits in state 7, then WB with rd=5.
- Store 0x0020B823 (sd x2,16(x1)) -> o_dmem_we=1 with o_dmem_req; state 10 is never entered.
- 0x00100013 (addi x0,x0,1) -> state 10 visited, o_RegWrite stays 0.
- Halt and timeout cases:
  - 0xFFFFFFFF -> HALT after ID; o_halt=1; later i_start ignored.
  - Separately, withhold i_imem_valid for 255 cycles -> o_error=1, state 12.
